ascii_varies_parser: RTL and testbench

- Decodes a line-oriented ASCII byte stream into the packed 16 x 8-bit value bus that the on-screen numeric overlay consumes.
- Input is decimal fields such as "12 255,7\n", typically from the UART RX path.
- The block is the receive-side inverse of the binary-to-ASCII string formatter.
- It accumulates digits, converts each field to binary, and publishes the whole value bank atomically on each line terminator.

---
 rtl/ascii_varies_parser_if.sv | 34 +++
 rtl/ascii_varies_parser.sv | 241 ++++++++++++++++++++++++
 tb/tb_ascii_varies_parser.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ascii_varies_parser_if.sv
// ---------------------------------------------------------------------------
// ascii_varies_parser_if
// Byte-stream input handshake and committed value-bank outputs of the ASCII
// value parser, grouped into one bundle.
//   i_valid  : sender has a byte on i_data
//   i_data   : ASCII byte
//   o_ready  : parser accepts i_data when i_valid && o_ready
//   o_varies : committed value bank, field k at [k*8 +: 8]
//   o_update : one-cycle pulse when o_varies changes
//   o_count  : number of fields written by the last committed line
//   o_err    : one-cycle pulse when a line is discarded
// Modports: master = byte source / bank consumer, slave = the parser.
// ---------------------------------------------------------------------------
interface ascii_varies_parser_if #(
  parameter int N_FIELDS = 16
) ();
  logic                    i_valid;
  logic [7:0]              i_data;
  logic                    o_ready;
  logic [N_FIELDS*8-1:0]   o_varies;
  logic                    o_update;
  logic [4:0]              o_count;
  logic                    o_err;

  modport master (
    output i_valid, i_data,
    input  o_ready, o_varies, o_update, o_count, o_err
  );

  modport slave (
    input  i_valid, i_data,
    output o_ready, o_varies, o_update, o_count, o_err
  );
endinterface

// File: rtl/ascii_varies_parser.sv
// ---------------------------------------------------------------------------
// ascii_varies_parser
// Decodes a line-oriented ASCII stream of decimal fields ("12 255,7\n") into
// a packed bank of N_FIELDS 8-bit values. Fields are separated by space or
// comma, CR is ignored, LF terminates and atomically commits the line.
// Values above 255 saturate; a malformed line is discarded with an o_err
// pulse and leaves the committed bank untouched.
//
// Optional feature (macro PARSER_HEX_EN): fields written "0x.."/"0X.." with
// one or two hex digits are accepted as hexadecimal.
//
// Ports:
//   sys_clk : clock, all logic on rising edge
//   sys_rst : synchronous active-high reset
//   bus     : ascii_varies_parser_if.slave (byte handshake + value outputs)
// ---------------------------------------------------------------------------
module ascii_varies_parser #(
  parameter int N_FIELDS   = 16,
  parameter int MAX_DIGITS = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  ascii_varies_parser_if.slave  bus
);

  localparam int IDX_W  = $clog2(N_FIELDS + 1);
  localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [IDX_W-1:0]  IDX_FULL = IDX_W'(N_FIELDS);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(MAX_DIGITS);
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_CR = 8'h0D;

  typedef enum logic [1:0] {S_IDLE, S_DIGIT, S_DROP, S_COMMIT} state_t;

  function automatic logic is_dig(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_sep(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h2C);
  endfunction

  function automatic logic [7:0] sat8(input logic [9:0] a);
    return (a > 10'd255) ? 8'hFF : a[7:0];
  endfunction

`ifdef PARSER_HEX_EN
  function automatic logic is_hex(input logic [7:0] c);
    return is_dig(c) || ((c >= 8'h61) && (c <= 8'h66)) || ((c >= 8'h41) && (c <= 8'h46));
  endfunction

  // Letters a-f / A-F share low nibbles 1..6, so +9 maps them to 10..15.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return is_dig(c) ? c[3:0] : 4'(c[3:0] + 4'd9);
  endfunction

  logic r_hex;
  logic w_hex_nxt;
`endif

  state_t                r_state, w_state_nxt;
  logic [9:0]            r_acc, w_acc_nxt;
  logic [DCNT_W-1:0]     r_dcnt, w_dcnt_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [N_FIELDS*8-1:0] r_shadow, w_shadow_st;
  logic [N_FIELDS*8-1:0] r_varies;
  logic [IDX_W-1:0]      r_count, w_cnt_nxt;
  logic                  r_err;

  logic w_accept, w_store, w_commit, w_err, w_clear, w_fld_end, w_fld_lf;
  logic [7:0] w_c;

  assign w_c      = bus.i_data;
  assign w_accept = bus.i_valid && bus.o_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_dcnt_nxt  = r_dcnt;
`ifdef PARSER_HEX_EN
    w_hex_nxt   = r_hex;
`endif
    w_store     = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    w_clear     = 1'b0;
    w_fld_end   = 1'b0;
    w_fld_lf    = 1'b0;
    w_shadow_st = r_shadow;

    if (r_state == S_COMMIT) begin
      // Bank already published on the LF edge; start a fresh line.
      w_state_nxt = S_IDLE;
      w_clear     = 1'b1;
    end else if (w_accept && (w_c != C_CR)) begin
      case (r_state)
        S_IDLE: begin
          if (is_dig(w_c)) begin
            w_acc_nxt   = 10'(w_c[3:0]);
            w_dcnt_nxt  = DCNT_W'(1);
`ifdef PARSER_HEX_EN
            w_hex_nxt   = 1'b0;
`endif
            w_state_nxt = S_DIGIT;
          end else if (is_sep(w_c)) begin
            w_state_nxt = S_IDLE;
          end else if (w_c == C_LF) begin
            w_commit    = 1'b1;
            w_state_nxt = S_COMMIT;
          end else begin
            w_state_nxt = S_DROP;
          end
        end

        S_DIGIT: begin
`ifdef PARSER_HEX_EN
          if (r_hex) begin
            if (is_hex(w_c)) begin
              if (r_dcnt < DCNT_W'(2)) begin
                w_acc_nxt  = (r_acc << 4) | 10'(hex_val(w_c));
                w_dcnt_nxt = r_dcnt + 1'b1;
              end else begin
                w_state_nxt = S_DROP;
              end
            end else if (is_sep(w_c) || (w_c == C_LF)) begin
              // A bare "0x" carries no value and is malformed.
              if (r_dcnt == '0) begin
                if (w_c == C_LF) w_err = 1'b1;
                else             w_state_nxt = S_DROP;
              end else begin
                w_fld_end = 1'b1;
                w_fld_lf  = (w_c == C_LF);
              end
            end else begin
              w_state_nxt = S_DROP;
            end
          end else if (((w_c == 8'h78) || (w_c == 8'h58)) && (r_dcnt == DCNT_W'(1)) && (r_acc == '0)) begin
            // Leading '0' followed by x/X: restart the digit count in hex mode.
            w_hex_nxt  = 1'b1;
            w_dcnt_nxt = '0;
          end else
`endif
          if (is_dig(w_c)) begin
            if (r_dcnt < DCNT_MAX) begin
              w_acc_nxt  = 10'(r_acc * 10'd10) + 10'(w_c[3:0]);
              w_dcnt_nxt = r_dcnt + 1'b1;
            end else begin
              w_state_nxt = S_DROP;
            end
          end else if (is_sep(w_c) || (w_c == C_LF)) begin
            w_fld_end = 1'b1;
            w_fld_lf  = (w_c == C_LF);
          end else begin
            w_state_nxt = S_DROP;
          end
        end

        S_DROP: begin
          if (w_c == C_LF) w_err = 1'b1;
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end

    // Field completion: store into the shadow bank unless it is already full.
    if (w_fld_end) begin
      if (r_idx == IDX_FULL) begin
        if (w_fld_lf) w_err = 1'b1;
        else          w_state_nxt = S_DROP;
      end else begin
        w_store = 1'b1;
        if (w_fld_lf) begin
          w_commit    = 1'b1;
          w_state_nxt = S_COMMIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    end

    if (w_err) begin
      w_clear     = 1'b1;
      w_state_nxt = S_IDLE;
    end

    if (w_store) w_shadow_st[int'(r_idx)*8 +: 8] = sat8(r_acc);
  end

  assign w_cnt_nxt = w_store ? (r_idx + 1'b1) : r_idx;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_dcnt   <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_varies <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
`ifdef PARSER_HEX_EN
      r_hex    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err;
      if (w_clear) begin
        r_acc    <= '0;
        r_dcnt   <= '0;
        r_idx    <= '0;
        r_shadow <= '0;
`ifdef PARSER_HEX_EN
        r_hex    <= 1'b0;
`endif
      end else begin
        r_acc  <= w_acc_nxt;
        r_dcnt <= w_dcnt_nxt;
`ifdef PARSER_HEX_EN
        r_hex  <= w_hex_nxt;
`endif
        if (w_store) begin
          r_shadow <= w_shadow_st;
          r_idx    <= r_idx + 1'b1;
        end
      end
      // Publish on the LF edge so the bank is valid alongside o_update.
      if (w_commit) begin
        r_varies <= w_shadow_st;
        r_count  <= w_cnt_nxt;
      end
    end
  end

  assign bus.o_ready  = (r_state != S_COMMIT);
  assign bus.o_update = (r_state == S_COMMIT);
  assign bus.o_err    = r_err;
  assign bus.o_varies = r_varies;
  assign bus.o_count  = 5'(r_count);

endmodule

// File: tb/tb_ascii_varies_parser.sv
module tb_ascii_varies_parser;

  localparam int NF = 16;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  ascii_varies_parser_if #(.N_FIELDS(NF)) bus ();

  ascii_varies_parser #(.N_FIELDS(NF), .MAX_DIGITS(3)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit           is_err;
    logic [127:0] v;
    int           cnt;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  logic [127:0] last_v   = '0;
  int           last_c   = 0;
  bit           prev_lf  = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_upd(input logic [127:0] v, input int cnt);
    exp_t e;
    e.is_err = 1'b0; e.v = v; e.cnt = cnt;
    sb_q.push_back(e);
    last_v = v; last_c = cnt;
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.v = last_v; e.cnt = last_c;
    sb_q.push_back(e);
  endtask

  function automatic logic [127:0] f3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [127:0] v;
    v = '0; v[7:0] = a; v[15:8] = b; v[23:16] = c;
    return v;
  endfunction

  // Called at posedge+1: drive a byte and hold it until accepted.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    bus.i_valid = 1'b1;
    bus.i_data  = b;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge sys_clk);
      if (bus.o_ready) begin
        @(posedge sys_clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("handshake_timeout", 0, 1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  function automatic string seq_line(input int n);
    string s;
    s = "";
    for (int i = 1; i <= n; i++) s = {s, (i > 1) ? " " : "", $sformatf("%0d", i)};
    return {s, "\n"};
  endfunction

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (cyc > 20000) begin
      $display("FAIL watchdog: got cycle %0d, required under 20000", cyc);
      $fatal(1, "watchdog");
    end
  end

  // Monitor: every o_update / o_err pulse is matched against the scoreboard.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      chk("ready_low_only_in_commit", bus.o_ready, !bus.o_update);
      if (prev_lf || bus.o_update || bus.o_err)
        chk("latency_after_lf", bus.o_update | bus.o_err, prev_lf);
      if (bus.o_update || bus.o_err) begin
        chk("upd_err_exclusive", bus.o_update & bus.o_err, 0);
        if (sb_q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("event_kind_err", bus.o_err, e.is_err);
          chk("o_varies", bus.o_varies, e.v);
          chk("o_count", bus.o_count, e.cnt);
        end
      end
    end
    prev_lf = bus.i_valid && bus.o_ready && (bus.i_data == 8'h0A) && !sys_rst;
  end

  initial begin
    logic [127:0] v16;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    sys_rst     = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_o_varies", bus.o_varies, 0);
    chk("rst_o_count",  bus.o_count, 0);
    chk("rst_o_update", bus.o_update, 0);
    chk("rst_o_err",    bus.o_err, 0);
    chk("rst_o_ready",  bus.o_ready, 1);
    @(posedge sys_clk); #1;

    // Lines are sent back-to-back so i_valid stays high across COMMIT.
    push_upd(f3(8'h0C, 8'hFF, 8'h07), 3);
    send_str("12 255,7\n");
    push_upd(f3(8'hFF, 8'h05, 8'h00), 2);
    send_str("300  ,,  5\r\n");
    push_upd(f3(8'h09, 8'h00, 8'h00), 1);
    send_str("9\n");
    push_err();
    send_str("1234\n");
    push_upd(f3(8'hFF, 8'hFF, 8'h00), 3);
    send_str("255 256 0\n");
    push_err();
    send_str("1a\n");
    push_err();
    send_str(seq_line(17));
    v16 = '0;
    for (int k = 0; k < 16; k++) v16[k*8 +: 8] = 8'(k + 1);
    push_upd(v16, 16);
    send_str(seq_line(16));
    push_err();
    send_str("0x1F 0XaB 0x\n");
`ifdef PARSER_HEX_EN
    push_upd(f3(8'h1F, 8'hAB, 8'h00), 2);
`else
    push_err();
`endif
    send_str("0x1F 0XaB\n");

    // Partial line then reset: the line is lost and the bank returns to 0.
    send_str("4 5");
    bus.i_valid = 1'b0;
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    last_v = '0; last_c = 0;
    @(negedge sys_clk);
    chk("rst_mid_o_varies", bus.o_varies, 0);
    chk("rst_mid_o_count",  bus.o_count, 0);
    chk("rst_mid_o_ready",  bus.o_ready, 1);
    @(posedge sys_clk); #1;
    push_upd('0, 0);
    send_str("\n");
    push_upd(f3(8'h2A, 8'h00, 8'h00), 1);
    send_str("42\n");

    bus.i_valid = 1'b0;
    repeat (6) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
